norm_lzc_pipe: RTL and testbench
================================

// Module: norm_lzc_pipe
// PURPOSE
//  Parametrised, pipelined leading-one normaliser for the Normalization datapath.
//  Per accepted word:
//   - finds the leading-one position and the left-shift count;
//   - left-justifies the word;
//   - extracts the two bits directly below the leading one.
//  Sits between the accumulator output and the exponent/rounding logic.
//  Valid/ready streaming; 3-stage pipeline with full backpressure and an optional shift cap.
// PARAMETERS
//  W          10        data width, >= 4
//  MAX_SHIFT  W-1       largest left shift applied; larger counts saturate
//  TAG_W      2         sideband tag width, passed through unchanged
//  SW (local) clog2(W)  width of shift/pos fields
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      input word present
//  in_ready   out  1      block accepts input this cycle
//  in_data    in   W      unsigned value to normalise
//  in_tag     in   TAG_W  sideband, delivered with the result
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  out_norm   out  W      in_data << out_shift
//  out_shift  out  SW     applied shift = min(lzc, MAX_SHIFT)
//  out_pos    out  SW     true leading-one bit index = W-1-lzc
//  out_frac   out  2      out_norm[W-2:W-3]; bits below the leading one
//  out_zero   out  1      in_data was all zeros
//  out_sat    out  1      lzc > MAX_SHIFT; shift capped
//  out_tag    out  TAG_W  in_tag of the same word
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids = 0, out_valid = 0, every output = 0.
//    Reset mid-stream discards all in-flight words.
//  - Transfer rules:
//    - input transfer when in_valid & in_ready;
//    - output transfer when out_valid & out_ready.
//  - Global pipe enable: en = !(v3 & !out_ready); in_ready = en (combinational, no in_valid dependence).
//  - When en = 1, every stage advances (bubbles included).
//  - When en = 0, all stage registers hold; out_* remain stable while out_valid & !out_ready.
//  - Stages:
//    - S1: register in_data/in_tag, v1 <= in_valid.
//    - S2: lzc via priority encoder, zero flag; register the data.
//    - S3: barrel shift by min(lzc, MAX_SHIFT); compute frac, pos, sat; drive outputs.
//  - Latency: 3 cycles from input transfer to out_valid with no stall.
//  - Throughput: 1 word/clk.
//  - Order is preserved; no word is dropped or duplicated.
//  - Zero input: out_zero = 1, out_norm = 0, out_shift = 0, out_pos = 0, out_frac = 0, out_sat = 0.
//  - Saturation: out_shift = MAX_SHIFT, out_norm = in_data << MAX_SHIFT, out_sat = 1;
//    out_pos is still the true index, and out_frac is taken from the shifted word.
//  - Arithmetic: all unsigned; shifted-out bits never occur (shift <= lzc); vacated bits = 0.
//  - Simultaneous stall release and new input: accepted the same cycle in_ready = 1.
// STRUCTURE
//  - Shared header norm_defs.vh: clog2 function, default W/TAG_W, FRAC_BITS = 2.
//  - Sub-module lzc_enc (combinational, parameter W):
//    - data -> lzc[SW-1:0], zero;
//    - MSB-first priority;
//    - lzc = 0 when zero.
//  - Top: three register stages, enable logic, barrel shifter.
// TESTING (W=10, MAX_SHIFT=9 unless noted)
//  1. in=10'b0000010110, tag=2 -> after 3 clk: norm=10'b1011000000, shift=5, pos=4, frac=01, tag=2.
//  2. in=10'h200 -> shift=0, pos=9, frac=00.
//     in=10'h001 -> norm=10'h200, shift=9, pos=0.
//  3. in=0 -> zero=1; norm, shift, pos, frac = 0; sat=0.
//  4. MAX_SHIFT=4, in=10'h001 -> norm=10'h010, shift=4, pos=0, sat=1.
//  5. Back-to-back 8 words with out_ready low for 5 cycles mid-stream:
//     - in_ready = 0 while stalled; outputs stable;
//     - all 8 results in order with matching tags.
//  6. Assert rst with 3 words in flight:
//     - out_valid = 0 immediately; nothing emitted afterwards;
//     - first post-reset word appears 3 clk after its transfer.

Source files
------------

// File: rtl/norm_lzc_pipe_pkg.sv
// Shared definitions for the leading-one normaliser: default widths,
// fraction field size and the constant-width helper.
package norm_lzc_pipe_pkg;

    localparam int DEF_W     = 10;
    localparam int DEF_TAG_W = 2;
    localparam int FRAC_BITS = 2;

    // Ceiling log2, never below 1 so a field always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/norm_lzc_pipe_if.sv
// Streaming interface of the normaliser: input word/tag handshake and the
// normalised result bundle with its own handshake.
interface norm_lzc_pipe_if
    import norm_lzc_pipe_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int TAG_W = DEF_TAG_W
);
    localparam int SW = clog2(W);

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_norm;
    logic [SW-1:0]        out_shift;
    logic [SW-1:0]        out_pos;
    logic [FRAC_BITS-1:0] out_frac;
    logic                 out_zero;
    logic                 out_sat;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_norm, out_shift, out_pos,
               out_frac, out_zero, out_sat, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_norm, out_shift, out_pos,
               out_frac, out_zero, out_sat, out_tag
    );

endinterface

// File: rtl/norm_lzc_pipe_lzc_enc.sv
// Combinational leading-zero counter: MSB-first priority encoder with an
// all-zero flag; the count reads 0 for an all-zero word.
module lzc_enc
    import norm_lzc_pipe_pkg::*;
#(
    parameter  int W  = DEF_W,
    localparam int SW = clog2(W)
) (
    input  logic [W-1:0]  data,
    output logic [SW-1:0] lzc,
    output logic          zero
);

    // Ascending scan: the highest set bit is the last to write, so it wins.
    always_comb begin
        lzc  = '0;
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                lzc  = SW'(W - 1 - i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_lzc_pipe.sv
// Three-stage leading-one normaliser with a single global stall enable,
// optional shift cap and tag pass-through.
module norm_lzc_pipe
    import norm_lzc_pipe_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int MAX_SHIFT = W - 1,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic            clk,
    input  logic            rst,
    norm_lzc_pipe_if.slave  io
);

    localparam int SW = clog2(W);

    function automatic logic is_sat(input logic [SW-1:0] lzc);
        return int'(lzc) > MAX_SHIFT;
    endfunction

    function automatic logic [SW-1:0] sat_shift(input logic [SW-1:0] lzc);
        if (is_sat(lzc)) return SW'(MAX_SHIFT);
        return lzc;
    endfunction

    logic                 en;

    logic                 vld_p1_d, vld_p1_q;
    logic                 vld_p2_d, vld_p2_q;
    logic                 vld_p3_d, vld_p3_q;

    logic [W-1:0]         data_p1_d, data_p1_q;
    logic [TAG_W-1:0]     tag_p1_d, tag_p1_q;

    logic [SW-1:0]        lzc_c;
    logic                 zero_c;
    logic [W-1:0]         data_p2_d, data_p2_q;
    logic [SW-1:0]        lzc_p2_d, lzc_p2_q;
    logic                 zero_p2_d, zero_p2_q;
    logic [TAG_W-1:0]     tag_p2_d, tag_p2_q;

    logic [SW-1:0]        shift_c;
    logic [W-1:0]         norm_c;
    logic [W-1:0]         norm_p3_d, norm_p3_q;
    logic [SW-1:0]        shift_p3_d, shift_p3_q;
    logic [SW-1:0]        pos_p3_d, pos_p3_q;
    logic [FRAC_BITS-1:0] frac_p3_d, frac_p3_q;
    logic                 zero_p3_d, zero_p3_q;
    logic                 sat_p3_d, sat_p3_q;
    logic [TAG_W-1:0]     tag_p3_d, tag_p3_q;

    // Only a valid, unaccepted result can stall; bubbles always advance.
    assign en          = !(vld_p3_q && !io.out_ready);
    assign io.in_ready = en;

    lzc_enc #(.W(W)) u_lzc (
        .data (data_p1_q),
        .lzc  (lzc_c),
        .zero (zero_c)
    );

    always_comb begin
        vld_p1_d = en ? io.in_valid : vld_p1_q;
        vld_p2_d = en ? vld_p1_q    : vld_p2_q;
        vld_p3_d = en ? vld_p2_q    : vld_p3_q;
    end

    always_comb begin
        // S1: capture word and tag
        data_p1_d  = en ? io.in_data : data_p1_q;
        tag_p1_d   = en ? io.in_tag  : tag_p1_q;

        // S2: leading-zero count and zero flag
        data_p2_d  = en ? data_p1_q : data_p2_q;
        lzc_p2_d   = en ? lzc_c     : lzc_p2_q;
        zero_p2_d  = en ? zero_c    : zero_p2_q;
        tag_p2_d   = en ? tag_p1_q  : tag_p2_q;

        // S3: capped barrel shift and derived fields
        shift_c    = sat_shift(lzc_p2_q);
        norm_c     = data_p2_q << shift_c;
        norm_p3_d  = en ? norm_c   : norm_p3_q;
        shift_p3_d = en ? shift_c  : shift_p3_q;
        pos_p3_d   = pos_p3_q;
        if (en) pos_p3_d = zero_p2_q ? '0 : SW'(W - 1) - lzc_p2_q;
        frac_p3_d  = en ? norm_c[W-2 -: FRAC_BITS] : frac_p3_q;
        zero_p3_d  = en ? zero_p2_q          : zero_p3_q;
        sat_p3_d   = en ? is_sat(lzc_p2_q)   : sat_p3_q;
        tag_p3_d   = en ? tag_p2_q           : tag_p3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
        end
    end

    always_ff @(posedge clk) begin
        data_p1_q  <= data_p1_d;
        tag_p1_q   <= tag_p1_d;
        data_p2_q  <= data_p2_d;
        lzc_p2_q   <= lzc_p2_d;
        zero_p2_q  <= zero_p2_d;
        tag_p2_q   <= tag_p2_d;
        norm_p3_q  <= norm_p3_d;
        shift_p3_q <= shift_p3_d;
        pos_p3_q   <= pos_p3_d;
        frac_p3_q  <= frac_p3_d;
        zero_p3_q  <= zero_p3_d;
        sat_p3_q   <= sat_p3_d;
        tag_p3_q   <= tag_p3_d;
    end

    // Data flops carry no reset; gating by valid keeps idle outputs at zero.
    always_comb begin
        io.out_valid = vld_p3_q;
        io.out_norm  = vld_p3_q ? norm_p3_q  : '0;
        io.out_shift = vld_p3_q ? shift_p3_q : '0;
        io.out_pos   = vld_p3_q ? pos_p3_q   : '0;
        io.out_frac  = vld_p3_q ? frac_p3_q  : '0;
        io.out_zero  = vld_p3_q ? zero_p3_q  : 1'b0;
        io.out_sat   = vld_p3_q ? sat_p3_q   : 1'b0;
        io.out_tag   = vld_p3_q ? tag_p3_q   : '0;
    end

endmodule

// File: tb/tb_norm_lzc_pipe.sv
// Directed bench for norm_lzc_pipe: one uncapped (MAX_SHIFT=9) and one
// capped (MAX_SHIFT=4) instance share the same stimulus.
module tb_norm_lzc_pipe;
    import norm_lzc_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] in_data  = '0;
    logic [1:0] in_tag   = '0;
    logic       out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    norm_lzc_pipe_if #(.W(10), .TAG_W(2)) if_a ();
    norm_lzc_pipe_if #(.W(10), .TAG_W(2)) if_b ();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_data   = in_data;
    assign if_a.in_tag    = in_tag;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_data   = in_data;
    assign if_b.in_tag    = in_tag;
    assign if_b.out_ready = out_ready;

    norm_lzc_pipe #(.W(10), .MAX_SHIFT(9), .TAG_W(2)) dut_a (.clk(clk), .rst(rst), .io(if_a.slave));
    norm_lzc_pipe #(.W(10), .MAX_SHIFT(4), .TAG_W(2)) dut_b (.clk(clk), .rst(rst), .io(if_b.slave));

    logic [9:0] w_data [8] = '{10'h3FF, 10'h155, 10'h080, 10'h0C3, 10'h040, 10'h003, 10'h000, 10'h025};
    logic [1:0] w_tag  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [9:0] w_norm [8] = '{10'h3FF, 10'h2AA, 10'h200, 10'h30C, 10'h200, 10'h300, 10'h000, 10'h250};
    logic [3:0] w_shift[8] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd8, 4'd0, 4'd4};
    logic [3:0] w_pos  [8] = '{4'd9, 4'd8, 4'd7, 4'd7, 4'd6, 4'd1, 4'd0, 4'd5};

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input bit use_b, input logic [9:0] norm,
                           input logic [3:0] shift, input logic [3:0] pos, input logic [1:0] frac,
                           input logic zero, input logic sat, input logic [1:0] tg);
        chk({nm, ".valid"}, 32'(use_b ? if_b.out_valid : if_a.out_valid), 32'd1);
        chk({nm, ".norm"},  32'(use_b ? if_b.out_norm  : if_a.out_norm),  32'(norm));
        chk({nm, ".shift"}, 32'(use_b ? if_b.out_shift : if_a.out_shift), 32'(shift));
        chk({nm, ".pos"},   32'(use_b ? if_b.out_pos   : if_a.out_pos),   32'(pos));
        chk({nm, ".frac"},  32'(use_b ? if_b.out_frac  : if_a.out_frac),  32'(frac));
        chk({nm, ".zero"},  32'(use_b ? if_b.out_zero  : if_a.out_zero),  32'(zero));
        chk({nm, ".sat"},   32'(use_b ? if_b.out_sat   : if_a.out_sat),   32'(sat));
        chk({nm, ".tag"},   32'(use_b ? if_b.out_tag   : if_a.out_tag),   32'(tg));
    endtask

    // Offer one word, then wait until it reaches the output stage.
    task automatic send_single(input string nm, input logic [9:0] d, input logic [1:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
        tick();
        chk({nm, ".early"}, 32'(if_a.out_valid), 32'd0);
        tick();
    endtask

    initial begin
        int  tx;
        int  rx;
        bit  was_stalled;
        bit  acc;
        logic [9:0] prev_norm;
        logic [1:0] prev_tag;

        tick();
        tick();
        chk("rst.valid_a", 32'(if_a.out_valid), 32'd0);
        chk("rst.valid_b", 32'(if_b.out_valid), 32'd0);
        chk("rst.norm",    32'(if_a.out_norm),  32'd0);
        chk("rst.tag",     32'(if_a.out_tag),   32'd0);
        #2 rst = 1'b0;
        tick();

        send_single("t1", 10'h016, 2'd2);
        chk_out("t1a", 1'b0, 10'h2C0, 4'd5, 4'd4, 2'b01, 1'b0, 1'b0, 2'd2);
        chk_out("t1b", 1'b1, 10'h160, 4'd4, 4'd4, 2'b10, 1'b0, 1'b1, 2'd2);

        send_single("t2", 10'h200, 2'd1);
        chk_out("t2a", 1'b0, 10'h200, 4'd0, 4'd9, 2'b00, 1'b0, 1'b0, 2'd1);

        send_single("t2l", 10'h001, 2'd3);
        chk_out("t2la", 1'b0, 10'h200, 4'd9, 4'd0, 2'b00, 1'b0, 1'b0, 2'd3);
        chk_out("t4b",  1'b1, 10'h010, 4'd4, 4'd0, 2'b00, 1'b0, 1'b1, 2'd3);

        send_single("t3", 10'h000, 2'd0);
        chk_out("t3a", 1'b0, 10'h000, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 2'd0);
        chk_out("t3b", 1'b1, 10'h000, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 2'd0);

        tick();
        tick();

        // Burst of 8 words with a 5-cycle consumer stall in the middle.
        tx = 0;
        rx = 0;
        was_stalled = 1'b0;
        in_valid = 1'b1;
        in_data  = w_data[0];
        in_tag   = w_tag[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 10);
            #1;
            if (was_stalled) begin
                chk("t5.hold_norm", 32'(if_a.out_norm), 32'(prev_norm));
                chk("t5.hold_tag",  32'(if_a.out_tag),  32'(prev_tag));
            end
            if (if_a.out_valid && !out_ready)
                chk("t5.in_ready_stall", 32'(if_a.in_ready), 32'd0);
            if (if_a.out_valid && out_ready) begin
                if (rx < 8) begin
                    chk("t5.norm",  32'(if_a.out_norm),  32'(w_norm[rx]));
                    chk("t5.shift", 32'(if_a.out_shift), 32'(w_shift[rx]));
                    chk("t5.pos",   32'(if_a.out_pos),   32'(w_pos[rx]));
                    chk("t5.tag",   32'(if_a.out_tag),   32'(w_tag[rx]));
                end else begin
                    chk("t5.extra", 32'(rx), 32'd7);
                end
                rx++;
            end
            was_stalled = if_a.out_valid && !out_ready;
            prev_norm   = if_a.out_norm;
            prev_tag    = if_a.out_tag;
            acc         = in_valid && if_a.in_ready;
            tick();
            if (acc) begin
                tx++;
                if (tx < 8) begin
                    in_data = w_data[tx];
                    in_tag  = w_tag[tx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("t5.count", 32'(rx), 32'd8);
        out_ready = 1'b1;

        // Reset with three words in flight.
        in_valid = 1'b1;
        in_data = 10'h016; in_tag = 2'd1; tick();
        in_data = 10'h200; in_tag = 2'd2; tick();
        in_data = 10'h001; in_tag = 2'd3; tick();
        in_valid = 1'b0;
        chk("t6.full", 32'(if_a.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6.async_valid", 32'(if_a.out_valid), 32'd0);
        chk("t6.async_norm",  32'(if_a.out_norm),  32'd0);
        chk("t6.async_tag",   32'(if_a.out_tag),   32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6.drained", 32'(if_a.out_valid), 32'd0);
        end
        send_single("t6p", 10'h0F0, 2'd1);
        chk_out("t6pa", 1'b0, 10'h3C0, 4'd2, 4'd7, 2'b11, 1'b0, 1'b0, 2'd1);
        chk_out("t6pb", 1'b1, 10'h3C0, 4'd2, 4'd7, 2'b11, 1'b0, 1'b0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
